// File: rtl/ahb_pkg.sv
// Shared constants, state encoding and field helpers for the AHB bus arbiter.
package ahb_pkg;

    localparam int unsigned AHB_AW = 32;
    localparam int unsigned AHB_DW = 32;

    localparam int unsigned RWTYP_HI = 29;
    localparam int unsigned RWTYP_LO = 27;

    localparam int unsigned M_LSU = 0;
    localparam int unsigned M_IFU = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_BUSY  = 2'd2
    } ahb_state_e;

    function automatic logic [2:0] rwtyp_of(input logic [AHB_AW-1:0] addr);
        return addr[RWTYP_HI:RWTYP_LO];
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module ahb_rr_picker #(
    parameter int unsigned NUM_M  = 2,
    parameter int unsigned MIDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic [NUM_M-1:0]  req,
    input  logic [MIDX_W-1:0] ptr,
    output logic              vld,
    output logic [MIDX_W-1:0] idx
);

    // Scan from the farthest position back toward ptr so the nearest hit wins.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int k = NUM_M - 1; k >= 0; k--) begin
            int unsigned j;
            j = (int'(ptr) + k) % NUM_M;
            if (req[j[MIDX_W-1:0]]) begin
                vld = 1'b1;
                idx = j[MIDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin arbiter sharing one simplified AHB slave port among NUM_M masters.
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter int unsigned NUM_M     = 2,
    parameter int unsigned MIDX_W    = (NUM_M > 1) ? $clog2(NUM_M) : 1,
    parameter int unsigned GRANT_TMO = 16,
    parameter int unsigned TMO_W     = $clog2(GRANT_TMO + 1)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_M-1:0]         hbusreq_m,
    input  logic [NUM_M-1:0]         haddr_ctrl_m,
    input  logic [NUM_M-1:0]         hwrite_m,
    input  logic [NUM_M*AHB_AW-1:0]  haddr_m,
    input  logic [NUM_M*AHB_DW-1:0]  hwdata_m,
    output logic [NUM_M-1:0]         hgrant_m,
    output logic [NUM_M-1:0]         hready_m,
    output logic [NUM_M-1:0]         hresp_m,
    output logic [AHB_AW-1:0]        haddr_s,
    output logic                     haddr_ctrl_s,
    output logic                     hwrite_s,
    output logic [AHB_DW-1:0]        hwdata_s,
    output logic [MIDX_W-1:0]        hmaster,
    input  logic                     hready_s,
    input  logic                     hresp_s
);

    ahb_state_e        state_q, state_d;
    logic [NUM_M-1:0]  hgrant_q, hgrant_d;
    logic [MIDX_W-1:0] hmaster_q, hmaster_d;
    logic [MIDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;

    logic [MIDX_W-1:0] nxt_ptr;
    logic [MIDX_W-1:0] pick_ptr;
    logic              pick_vld;
    logic [MIDX_W-1:0] pick_idx;
    logic              own_req;
    logic              own_ctrl;

    assign nxt_ptr  = (hmaster_q == MIDX_W'(NUM_M - 1)) ? '0 : hmaster_q + MIDX_W'(1);
    // On completion the owner ranks last, so arbitrate from the slot after it.
    assign pick_ptr = (state_q == S_BUSY) ? nxt_ptr : rr_ptr_q;
    assign own_req  = hbusreq_m[hmaster_q];
    assign own_ctrl = haddr_ctrl_m[hmaster_q];

    ahb_rr_picker #(
        .NUM_M  (NUM_M),
        .MIDX_W (MIDX_W)
    ) u_picker (
        .req (hbusreq_m),
        .ptr (pick_ptr),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        hgrant_d  = hgrant_q;
        hmaster_d = hmaster_q;
        rr_ptr_d  = rr_ptr_q;
        tmo_cnt_d = tmo_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d           = S_GRANT;
                    hmaster_d         = pick_idx;
                    hgrant_d          = '0;
                    hgrant_d[pick_idx] = 1'b1;
                    tmo_cnt_d         = '0;
                end
            end
            S_GRANT: begin
                if (own_ctrl) begin
                    state_d  = S_BUSY;
                    rr_ptr_d = nxt_ptr;
                end else if (!own_req || tmo_cnt_q == TMO_W'(GRANT_TMO - 1)) begin
                    state_d  = S_IDLE;
                    hgrant_d = '0;
                    rr_ptr_d = nxt_ptr;
                end else if (tmo_cnt_q != '1) begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            S_BUSY: begin
                if (hready_s) begin
                    rr_ptr_d = nxt_ptr;
                    hgrant_d = '0;
                    if (pick_vld) begin
                        state_d            = S_GRANT;
                        hmaster_d          = pick_idx;
                        hgrant_d[pick_idx] = 1'b1;
                        tmo_cnt_d          = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                hgrant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            hgrant_q  <= '0;
            hmaster_q <= '0;
            rr_ptr_q  <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            hgrant_q  <= hgrant_d;
            hmaster_q <= hmaster_d;
            rr_ptr_q  <= rr_ptr_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign hgrant_m = hgrant_q;
    assign hmaster  = hmaster_q;

    // Slave side is forced quiet in idle; responses reach only the busy owner.
    always_comb begin
        haddr_s      = '0;
        haddr_ctrl_s = 1'b0;
        hwrite_s     = 1'b0;
        hwdata_s     = '0;
        hready_m     = '0;
        hresp_m      = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (hmaster_q == MIDX_W'(i)) begin
                if (state_q != S_IDLE) begin
                    haddr_s      = haddr_m[i*AHB_AW +: AHB_AW];
                    haddr_ctrl_s = haddr_ctrl_m[i];
                    hwrite_s     = hwrite_m[i];
                    hwdata_s     = hwdata_m[i*AHB_DW +: AHB_DW];
                end
                hready_m[i] = hready_s & (state_q == S_BUSY);
                hresp_m[i]  = hresp_s & (state_q == S_BUSY);
            end
        end
    end

endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Shares one simplified AHB slave port between NUM_M masters, e.g. the LSU master (index 0) and the IFU master (index 1).
- Arbitrates hbusreq round-robin and drives a one-hot, registered hgrant.
- Muxes the granted master's address, control and write data to the slave.
- Returns hready/hresp only to the owning master, so idle masters never see a false response.

Parameters:
- NUM_M, 2, number of masters (2..8).
- MIDX_W, $clog2(NUM_M) (minimum 1), width of the owner index.
- GRANT_TMO, 16, cycles an owner may hold the grant in S_GRANT without driving haddr_ctrl before the grant is revoked.
- TMO_W, $clog2(GRANT_TMO+1), timeout counter width.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- hbusreq_m  in  NUM_M  per-master bus request
- haddr_ctrl_m  in  NUM_M  per-master address-phase valid
- hwrite_m  in  NUM_M  per-master write flag
- haddr_m  in  NUM_M*32  per-master address; slice i is [32*i+31:32*i]; bits 29:27 carry rwtyp
- hwdata_m  in  NUM_M*32  per-master write data
- hgrant_m  out  NUM_M  one-hot grant, registered
- hready_m  out  NUM_M  hready_s gated to the owner
- hresp_m  out  NUM_M  hresp_s gated to the owner
- haddr_s  out  32  muxed address to the slave
- haddr_ctrl_s  out  1  muxed address valid
- hwrite_s  out  1  muxed write flag
- hwdata_s  out  32  muxed write data
- hmaster  out  MIDX_W  current owner index
- hready_s  in  1  slave ready / transfer done
- hresp_s  in  1  slave error response

Behaviour:
Reset:
- FSM = S_IDLE; hgrant_m = 0; hmaster = 0; rr_ptr = 0; tmo_cnt = 0.
- All muxed slave outputs = 0; hready_m = 0; hresp_m = 0.

States:
- S_IDLE -> S_GRANT when |hbusreq_m.
  - Winner = first requester at or after rr_ptr, wrapping modulo NUM_M.
  - Registers hmaster = winner and hgrant_m = onehot(winner).
  - Grant latency: request in cycle n gives hgrant high in cycle n+1.
- S_GRANT -> S_BUSY when haddr_ctrl_m[hmaster] = 1.
- S_GRANT -> S_IDLE when hbusreq_m[hmaster] = 0 (request abandoned), or when tmo_cnt reaches GRANT_TMO-1 (revoke). Revocation clears hgrant_m in the following cycle.
- S_BUSY -> S_IDLE (or re-arbitrate) on hready_s = 1. hgrant_m stays held throughout S_BUSY.
- On leaving S_BUSY or S_GRANT: rr_ptr <= hmaster+1, wrapping to 0 at NUM_M.

Back-to-back requests:
- If another request, or the same master's request, is pending at S_BUSY completion, go directly to S_GRANT with the new winner. No idle bubble.
- The completing master ranks last.

Slave-side mux:
- haddr_s, hwrite_s, hwdata_s = slice[hmaster], combinational from the owner's inputs.
- haddr_ctrl_s = haddr_ctrl_m[hmaster] & (state != S_IDLE).
- In S_IDLE all slave-side outputs = 0.

Response gating:
- hready_m[i] = hready_s & (state == S_BUSY) & (hmaster == i). hresp_m is gated the same way.
- hready_s is ignored in S_IDLE and S_GRANT.

Timeout counter:
- tmo_cnt clears on entry to S_GRANT and increments each cycle in S_GRANT.
- Saturates; it is not used outside S_GRANT.

Simultaneous events:
- Requests from all masters in the same cycle: only one winner per arbitration.
- A request that drops in the same cycle as the grant registers is handled by the abandon path one cycle later.
- hresp_s = 1 with hready_s = 1 completes the transfer like OKAY; hresp is only forwarded, never acted on.

Reset mid-transfer:
- Everything returns to reset values immediately.
- The slave sees haddr_ctrl_s drop asynchronously.

Decomposition:
- Package ahb_pkg holds:
  - state encodings S_IDLE/S_GRANT/S_BUSY
  - AHB_AW = 32, AHB_DW = 32
  - rwtyp field position (29:27)
  - master index constants M_LSU = 0, M_IFU = 1
- Sub-module ahb_rr_picker: combinational round-robin first-one-after-pointer. Inputs req[NUM_M] and ptr; outputs vld and idx.

Test Plan:
- Single request: hbusreq_m = 2'b01 at cycle 0 -> hgrant_m = 01 at cycle 1. Master drives haddr_ctrl with addr 0x8000_1000. haddr_s = 0x8000_1000. hready_s high at cycle 4 -> hready_m = 01 at cycle 4 only; hgrant_m = 00 at cycle 5.
- Contention: both request at cycle 0 from reset -> M0 granted first.
  - M0 completes while M1 still requests -> hgrant_m = 10 the next cycle, with no idle cycle.
  - M1 completes with both requesting -> M0 granted.
- Gating: while M1 owns the bus and sits in S_GRANT, hready_s = 1 -> hready_m = 00. M0 never sees a response.
- Timeout: grant M0 with haddr_ctrl_m held 0 and GRANT_TMO = 16 -> hgrant_m drops 16 cycles after the grant. The pending M1 request is then granted.
- Abandon: M1 drops hbusreq one cycle after hgrant rises, without haddr_ctrl -> return to S_IDLE; rr_ptr = 0.
- Reset: rstn low during S_BUSY with hwdata_m = 0xDEAD_BEEF -> all outputs 0 asynchronously. After release, the first grant goes to the lowest-index requester.
